// File: rtl/cop_issue_pkg.sv
// Shared definitions for the core-side coprocessor interface: custom opcodes and FSM states.
package cop_issue_pkg;

  localparam logic [6:0] CUSTOM_0 = 7'b0001011;
  localparam logic [6:0] CUSTOM_1 = 7'b0101011;
  localparam logic [6:0] CUSTOM_2 = 7'b1011011;
  localparam logic [6:0] CUSTOM_3 = 7'b1111011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cop_issue_opc_filter.sv
// Flags an opcode as a custom opcode whose enable bit is set. Purely combinational.
module cop_issue_opc_filter
  import cop_issue_pkg::*;
#(
  parameter logic [3:0] OPC_EN = 4'b1111
) (
  input  logic [6:0] opc_i,
  output logic       en_o
);

  always_comb begin
    en_o = 1'b0;
    case (opc_i)
      CUSTOM_0: en_o = OPC_EN[0];
      CUSTOM_1: en_o = OPC_EN[1];
      CUSTOM_2: en_o = OPC_EN[2];
      CUSTOM_3: en_o = OPC_EN[3];
      default:  en_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cop_issue.sv
// Core-side initiator of the coprocessor interface: one instruction in flight, one registered response.
// Latency 2 cycles accept-to-response plus one per wait cycle; no accept while busy, rf stalls hold REQ.
module cop_issue
  import cop_issue_pkg::*;
#(
  parameter int         XLEN    = 64,
  parameter logic [3:0] OPC_EN  = 4'b1111,
  parameter int         TIMEOUT = 255
) (
  input  logic            cop_clk_i,
  input  logic            cop_rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_insn_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [4:0]      req_rd_idx_i,
  input  logic            rf_wr_ready_i,
  output logic            rsp_valid_o,
  output logic            rsp_wr_o,
  output logic [4:0]      rsp_rd_idx_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_illegal_o,
  output logic            rsp_timeout_o,
  output logic            busy_o,
  output logic            cop_valid_o,
  output logic            cop_rdywr_o,
  output logic [31:0]     cop_insn_o,
  output logic [XLEN-1:0] cop_rs1_o,
  output logic [XLEN-1:0] cop_rs2_o,
  input  logic            cop_ready_i,
  input  logic            cop_wait_i,
  input  logic            cop_wr_i,
  input  logic [XLEN-1:0] cop_rd_i
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic              req_ready_q;
  logic              busy_q;
  logic              cop_valid_q;
  logic              rsp_valid_q;
  logic              rsp_wr_q;
  logic              rsp_illegal_q;
  logic              rsp_timeout_q;
  logic [4:0]        rd_idx_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic [31:0]       insn_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic              opc_en;
  logic              accept;

  cop_issue_opc_filter #(
    .OPC_EN (OPC_EN)
  ) u_opc_filter (
    .opc_i (req_insn_i[6:0]),
    .en_o  (opc_en)
  );

  assign accept = req_valid_i & req_ready_q;
  assign cnt_d  = cnt_q + 8'd1;

  always_ff @(posedge cop_clk_i or negedge cop_rst_ni) begin
    if (!cop_rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      cop_valid_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_wr_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rd_idx_q      <= '0;
      rsp_data_q    <= '0;
      insn_q        <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            insn_q      <= req_insn_i;
            rs1_q       <= req_rs1_i;
            rs2_q       <= req_rs2_i;
            rd_idx_q    <= req_rd_idx_i;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            if (opc_en) begin
              state_q     <= ST_REQ;
              cop_valid_q <= 1'b1;
            end else begin
              state_q       <= ST_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_illegal_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // Wait beats the claim; a claim blocked by the regfile neither counts nor times out.
          if (cop_wait_i) begin
            cnt_q <= cnt_d;
            if (cnt_q == CNT_LAST) begin
              state_q       <= ST_RESP;
              cop_valid_q   <= 1'b0;
              rsp_valid_q   <= 1'b1;
              rsp_timeout_q <= 1'b1;
            end
          end else if (cop_wr_i) begin
            if (cop_ready_i) begin
              state_q     <= ST_RESP;
              cop_valid_q <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_wr_q    <= 1'b1;
              rsp_data_q  <= cop_rd_i;
            end
          end else begin
            state_q       <= ST_RESP;
            cop_valid_q   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_illegal_q <= 1'b1;
          end
        end
        ST_RESP: begin
          state_q       <= ST_IDLE;
          req_ready_q   <= 1'b1;
          busy_q        <= 1'b0;
          rsp_valid_q   <= 1'b0;
          rsp_wr_q      <= 1'b0;
          rsp_illegal_q <= 1'b0;
          rsp_timeout_q <= 1'b0;
          rsp_data_q    <= '0;
        end
        default: begin
          state_q       <= ST_IDLE;
          req_ready_q   <= 1'b1;
          busy_q        <= 1'b0;
          cop_valid_q   <= 1'b0;
          rsp_valid_q   <= 1'b0;
          rsp_wr_q      <= 1'b0;
          rsp_illegal_q <= 1'b0;
          rsp_timeout_q <= 1'b0;
          rsp_data_q    <= '0;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign busy_o        = busy_q;
  assign cop_valid_o   = cop_valid_q;
  assign cop_rdywr_o   = rf_wr_ready_i & (state_q == ST_REQ);
  assign cop_insn_o    = insn_q;
  assign cop_rs1_o     = rs1_q;
  assign cop_rs2_o     = rs2_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_wr_o      = rsp_wr_q;
  assign rsp_illegal_o = rsp_illegal_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign rsp_rd_idx_o  = rd_idx_q;
  assign rsp_data_o    = rsp_data_q;

endmodule

// File: tb/tb_cop_issue.sv
// Bench for cop_issue: default instance plus one with CUSTOM_1 disabled and TIMEOUT=4.
module tb_cop_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid_b;
  logic [31:0] req_insn;
  logic [63:0] req_rs1, req_rs2;
  logic [4:0]  req_rd_idx;
  logic        rf_wr_ready, cop_ready, cop_wait, cop_wr;
  logic [63:0] cop_rd;

  logic        req_ready, rsp_valid, rsp_wr, rsp_illegal, rsp_timeout, busy, cop_valid, cop_rdywr;
  logic [4:0]  rsp_rd_idx;
  logic [63:0] rsp_data, cop_rs1, cop_rs2;
  logic [31:0] cop_insn;
  logic        req_ready_b, rsp_valid_b, rsp_wr_b, rsp_illegal_b, rsp_timeout_b, busy_b, cop_valid_b, cop_rdywr_b;
  logic [4:0]  rsp_rd_idx_b;
  logic [63:0] rsp_data_b, cop_rs1_b, cop_rs2_b;
  logic [31:0] cop_insn_b;

  always #5 clk = ~clk;

  cop_issue dut (
    .cop_clk_i(clk), .cop_rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_insn_i(req_insn),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rd_idx_i(req_rd_idx),
    .rf_wr_ready_i(rf_wr_ready), .rsp_valid_o(rsp_valid), .rsp_wr_o(rsp_wr),
    .rsp_rd_idx_o(rsp_rd_idx), .rsp_data_o(rsp_data), .rsp_illegal_o(rsp_illegal),
    .rsp_timeout_o(rsp_timeout), .busy_o(busy), .cop_valid_o(cop_valid),
    .cop_rdywr_o(cop_rdywr), .cop_insn_o(cop_insn), .cop_rs1_o(cop_rs1), .cop_rs2_o(cop_rs2),
    .cop_ready_i(cop_ready), .cop_wait_i(cop_wait), .cop_wr_i(cop_wr), .cop_rd_i(cop_rd)
  );

  cop_issue #(.XLEN(64), .OPC_EN(4'b1101), .TIMEOUT(4)) dut_b (
    .cop_clk_i(clk), .cop_rst_ni(rst_n),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_insn_i(req_insn),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rd_idx_i(req_rd_idx),
    .rf_wr_ready_i(rf_wr_ready), .rsp_valid_o(rsp_valid_b), .rsp_wr_o(rsp_wr_b),
    .rsp_rd_idx_o(rsp_rd_idx_b), .rsp_data_o(rsp_data_b), .rsp_illegal_o(rsp_illegal_b),
    .rsp_timeout_o(rsp_timeout_b), .busy_o(busy_b), .cop_valid_o(cop_valid_b),
    .cop_rdywr_o(cop_rdywr_b), .cop_insn_o(cop_insn_b), .cop_rs1_o(cop_rs1_b), .cop_rs2_o(cop_rs2_b),
    .cop_ready_i(cop_ready), .cop_wait_i(cop_wait), .cop_wr_i(cop_wr), .cop_rd_i(cop_rd)
  );

  typedef struct {
    bit          on_b;
    logic [31:0] insn;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rd;
    int          nwait;
    bit          claim;
    logic [63:0] rdval;
    int          lat;
    bit          wr;
    bit          ill;
    bit          to;
  } vec_t;

  typedef struct {
    bit          wr;
    bit          ill;
    bit          to;
    logic [4:0]  idx;
    logic [63:0] data;
    int          cyc;
  } sb_t;

  localparam logic [31:0] I_C0 = {7'b0000000, 5'd4, 5'd1, 3'b001, 5'd6, 7'b0001011};
  localparam logic [31:0] I_C1 = {7'b1000000, 5'd3, 5'd2, 3'b000, 5'd5, 7'b0101011};
  localparam logic [31:0] I_C2 = {7'b0100000, 5'd7, 5'd9, 3'b010, 5'd1, 7'b1011011};
  localparam logic [31:0] I_C3 = {7'b0000001, 5'd8, 5'd6, 3'b111, 5'd2, 7'b1111011};
  localparam logic [31:0] I_OP = {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd5, 7'b0110011};

  vec_t vecs[10];
  sb_t  qa[$];
  sb_t  qb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    sb_t e;
    if (rst_n === 1'b1) begin
      if (rsp_valid) begin
        if (qa.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_a_unexpected: got rsp_valid=1, expected none (cycle %0d)", cyc);
        end else begin
          e = qa.pop_front();
          chk("rsp_a_fields", {rsp_wr, rsp_illegal, rsp_timeout, rsp_rd_idx, rsp_data},
              {e.wr, e.ill, e.to, e.idx, e.data});
          chk("rsp_a_cycle", cyc, e.cyc);
        end
      end
      if (rsp_valid_b) begin
        if (qb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_b_unexpected: got rsp_valid=1, expected none (cycle %0d)", cyc);
        end else begin
          e = qb.pop_front();
          chk("rsp_b_fields", {rsp_wr_b, rsp_illegal_b, rsp_timeout_b, rsp_rd_idx_b, rsp_data_b},
              {e.wr, e.ill, e.to, e.idx, e.data});
          chk("rsp_b_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  // Responses are sampled mid-cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && (busy || busy_b); i++) tick();
    chk("idle_reached", {busy, busy_b}, 2'b00);
    chk("req_ready_idle", {req_ready, req_ready_b}, 2'b11);
  endtask

  task automatic push_exp(input bit on_b, input bit wr, input bit ill, input bit to,
                          input logic [4:0] idx, input logic [63:0] data, input int lat);
    sb_t e;
    e.wr = wr; e.ill = ill; e.to = to; e.idx = idx;
    e.data = wr ? data : 64'd0;
    e.cyc = cyc + lat;
    if (on_b) qb.push_back(e);
    else qa.push_back(e);
  endtask

  task automatic drive_req(input bit on_b, input logic [31:0] insn, input logic [63:0] rs1,
                           input logic [63:0] rs2, input logic [4:0] rd);
    req_insn = insn; req_rs1 = rs1; req_rs2 = rs2; req_rd_idx = rd;
    req_valid = !on_b; req_valid_b = on_b;
    cop_wait = 1'b0; cop_wr = 1'b0;
    tick();
    req_valid = 1'b0; req_valid_b = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    logic        cv;
    logic [159:0] ops;
    push_exp(v.on_b, v.wr, v.ill, v.to, v.rd, v.rdval, v.lat);
    drive_req(v.on_b, v.insn, v.rs1, v.rs2, v.rd);
    for (int k = 1; k <= v.nwait + 1; k++) begin
      cv  = v.on_b ? cop_valid_b : cop_valid;
      ops = v.on_b ? {cop_insn_b, cop_rs1_b, cop_rs2_b} : {cop_insn, cop_rs1, cop_rs2};
      chk("cop_valid", cv, (k < v.lat));
      if (k < v.lat) chk("cop_ops_stable", ops, {v.insn, v.rs1, v.rs2});
      cop_wait = (k <= v.nwait);
      cop_wr   = v.claim;
      cop_rd   = (k <= v.nwait) ? ~v.rdval : v.rdval;
      tick();
    end
    cop_wait = 1'b0; cop_wr = 1'b0;
    wait_idle();
  endtask

  initial begin
    vecs[0] = '{0, I_C1, 64'h11, 64'h22, 5'd5, 0, 1, 64'hDEAD_BEEF, 2, 1, 0, 0};
    vecs[1] = '{0, I_C1, 64'hAAAA_0000_5555_FFFF, 64'h1234, 5'd7, 3, 1, 64'h0123_4567_89AB_CDEF, 5, 1, 0, 0};
    vecs[2] = '{0, I_C0, 64'h1, 64'h2, 5'd3, 0, 0, 64'h77, 2, 0, 1, 0};
    vecs[3] = '{0, I_OP, 64'h3, 64'h4, 5'd4, 0, 0, 64'h99, 1, 0, 1, 0};
    vecs[4] = '{0, I_C3, 64'h5, 64'h6, 5'd31, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1, 0, 0};
    vecs[5] = '{0, I_C2, 64'h7, 64'h8, 5'd0, 0, 1, 64'h1, 2, 1, 0, 0};
    vecs[6] = '{1, I_C1, 64'h9, 64'hA, 5'd8, 0, 1, 64'h55, 1, 0, 1, 0};
    vecs[7] = '{1, I_C0, 64'hB, 64'hC, 5'd12, 10, 0, 64'h0, 5, 0, 0, 1};
    vecs[8] = '{1, I_C2, 64'hD, 64'hE, 5'd13, 3, 1, 64'hBEEF_0000_0000_0001, 5, 1, 0, 0};
    vecs[9] = '{0, I_C0, 64'hF, 64'h10, 5'd14, 4, 1, 64'h4444, 6, 1, 0, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0;
    req_insn = '0; req_rs1 = '0; req_rs2 = '0; req_rd_idx = '0;
    rf_wr_ready = 1'b1; cop_ready = 1'b1; cop_wait = 1'b0; cop_wr = 1'b0; cop_rd = '0;
    #12;
    chk("reset_flags_a", {rsp_valid, rsp_wr, rsp_illegal, rsp_timeout, busy, cop_valid, cop_rdywr, req_ready},
        8'b0000_0001);
    chk("reset_flags_b", {rsp_valid_b, rsp_wr_b, rsp_illegal_b, rsp_timeout_b, busy_b, cop_valid_b,
        cop_rdywr_b, req_ready_b}, 8'b0000_0001);
    chk("reset_regs_a", {rsp_rd_idx, rsp_data, cop_insn, cop_rs1, cop_rs2}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Regfile port busy while the coprocessor claims: hold two cycles, then write back.
    push_exp(0, 1, 0, 0, 5'd9, 64'hCAFE, 4);
    drive_req(0, I_C1, 64'h31, 64'h32, 5'd9);
    rf_wr_ready = 1'b0; cop_ready = 1'b0; cop_wr = 1'b1; cop_rd = 64'hCAFE;
    #1 chk("rdywr_hold1", cop_rdywr, 1'b0);
    tick();
    chk("cop_valid_hold", cop_valid, 1'b1);
    #1 chk("rdywr_hold2", cop_rdywr, 1'b0);
    tick();
    rf_wr_ready = 1'b1; cop_ready = 1'b1;
    #1 chk("rdywr_free", cop_rdywr, 1'b1);
    tick();
    cop_wr = 1'b0;
    chk("rdywr_resp", cop_rdywr, 1'b0);
    wait_idle();

    // Reset in the middle of a transaction drops everything with no response afterwards.
    drive_req(0, I_C2, 64'h41, 64'h42, 5'd10);
    cop_wait = 1'b1;
    tick();
    chk("pre_reset_valid", {cop_valid, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {cop_valid, busy, rsp_valid, req_ready}, 4'b0001);
    tick();
    tick();
    cop_wait = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_reset_quiet", {busy, cop_valid, rsp_valid, req_ready}, 4'b0001);

    run_txn(vecs[0]);
    tick();
    tick();

    chk("sb_a_drained", qa.size(), 0);
    chk("sb_b_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
